// File: rtl/timer_ssg_counter_pkg.sv
// Shared constants and helpers for the cascaded BCD timer with seven-segment output.
// Holds the digit/segment widths, the digit limit and the segment table.
package timer_ssg_counter_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 6;

  // Segment bit 0 = a ... bit 6 = g, 1 = lit
  localparam logic [SEG_W-1:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
    return (d > 4'd9) ? '0 : SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/timer_ssg_counter_digit.sv
// One BCD digit of the cascade: 4-bit register with load, up/down step and carry chain.
// cout asserts when this digit steps past its terminal value and the next digit must move.
module bcd_digit
  import timer_ssg_counter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] value,
  input  logic             up_down,
  input  logic             cin,
  input  logic             hold,
  output logic [BCD_W-1:0] q,
  output logic             term,
  output logic             cout
);

  logic step;

  assign term = up_down ? (q == 4'd9) : (q == 4'd0);
  assign cout = cin & term;
  assign step = cin & ~hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= value;
    end else if (step) begin
      if (up_down) q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
      else         q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/timer_ssg_counter.sv
// Cascaded BCD up/down timer with preset, auto-reload, terminal-count pulse,
// sticky done flag and a combinational seven-segment image of the count.
module timer_ssg_counter
  import timer_ssg_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic                    up_down,
  input  logic                    auto_reload,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic [SEG_W*DIGITS-1:0] ssg,
  output logic                    tc,
  output logic                    en_machine
);

  logic [DIGITS-1:0] term;
  logic [DIGITS:0]   carry;
  logic              at_t;
  logic              step_req;
  logic              term_step;
  logic              reload;
  logic              dig_load;
  logic              load_src;

  assign at_t      = &term;
  assign step_req  = enable & ~load & ~en_machine;
  assign carry[0]  = step_req;
  // The full carry chain reaching the top means every digit sat at terminal.
  assign term_step = carry[DIGITS];
  assign reload    = term_step & auto_reload;
  assign dig_load  = load | reload;
  assign load_src  = load | ~up_down;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .reset   (reset),
      .load    (dig_load),
      .value   (load_src ? bcd_clamp(load_value[BCD_W*k +: BCD_W]) : '0),
      .up_down (up_down),
      .cin     (carry[k]),
      .hold    (at_t),
      .q       (count[BCD_W*k +: BCD_W]),
      .term    (term[k]),
      .cout    (carry[k+1])
    );
    assign ssg[SEG_W*k +: SEG_W] = seg_decode(count[BCD_W*k +: BCD_W]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc         <= 1'b0;
      en_machine <= 1'b0;
    end else if (load) begin
      tc         <= 1'b0;
      en_machine <= 1'b0;
    end else if (term_step) begin
      tc <= 1'b1;
      if (!auto_reload) en_machine <= 1'b1;
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_ssg_counter.sv
// Self-checking bench: integer-valued reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_timer_ssg_counter;

  localparam int D    = 3;
  localparam int MAXV = 999;

  logic            clk, reset, enable, load, up_down, auto_reload;
  logic [4*D-1:0]  load_value, count;
  logic [7*D-1:0]  ssg;
  logic            tc, en_machine;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  int m_count;
  bit m_tc, m_en;

  logic [6:0] segs [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  timer_ssg_counter #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .up_down(up_down),
    .auto_reload(auto_reload), .load_value(load_value), .count(count), .ssg(ssg),
    .tc(tc), .en_machine(en_machine)
  );

  always #5 clk = ~clk;

  function automatic int clamp_int(input logic [4*D-1:0] lv);
    int s = 0, p = 1, d;
    for (int k = 0; k < D; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      s += d * p;
      p *= 10;
    end
    return s;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7*D-1:0] to_ssg(input int v);
    logic [7*D-1:0] r = '0;
    for (int k = 0; k < D; k++) begin
      r[7*k +: 7] = segs[v % 10];
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count held as a plain integer
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count <= 0; m_tc <= 0; m_en <= 0;
    end else if (load) begin
      m_count <= clamp_int(load_value); m_tc <= 0; m_en <= 0;
    end else if (enable && !m_en) begin
      if (m_count == (up_down ? MAXV : 0)) begin
        m_tc <= 1;
        if (auto_reload) m_count <= up_down ? 0 : clamp_int(load_value);
        else m_en <= 1;
      end else begin
        m_count <= up_down ? m_count + 1 : m_count - 1;
        m_tc <= 0;
      end
    end else begin
      m_tc <= 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_count", count, to_bcd(m_count));
      check("model_ssg", ssg, to_ssg(m_count));
      check("model_tc", tc, m_tc);
      check("model_en", en_machine, m_en);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_load(input logic [4*D-1:0] v, input logic ud, input logic ar);
    load = 1; enable = 0; load_value = v; up_down = ud; auto_reload = ar;
    tick();
    load = 0;
  endtask

  initial begin
    int r;
    clk = 0; reset = 0; enable = 0; load = 0; up_down = 0; auto_reload = 0; load_value = '0;
    started = 1;
    #1;
    check("reset_count", count, 12'h000);
    check("reset_ssg", ssg, {7'h3F, 7'h3F, 7'h3F});
    check("reset_tc", tc, 1'b0);
    check("reset_en", en_machine, 1'b0);
    tick();
    reset = 1;
    tick();

    // Asynchronous reset mid-count, then count resumes from zero
    do_load(12'h456, 1'b1, 1'b0);
    enable = 1;
    tick();
    check("midcount_457", count, 12'h457);
    reset = 0;
    #1;
    check("async_rst_count", count, 12'h000);
    check("async_rst_ssg", ssg, {7'h3F, 7'h3F, 7'h3F});
    check("async_rst_tc", tc, 1'b0);
    check("async_rst_en", en_machine, 1'b0);
    enable = 0;
    reset = 1;
    tick();
    enable = 1;
    tick();
    check("after_rst_step", count, 12'h001);

    // Countdown to terminal without reload
    do_load(12'h005, 1'b0, 1'b0);
    enable = 1;
    for (int i = 4; i >= 0; i--) begin
      tick();
      check("down_seq", count, to_bcd(i));
      check("down_seq_tc", tc, 1'b0);
    end
    tick();
    check("term_tc", tc, 1'b1);
    check("term_en", en_machine, 1'b1);
    check("term_hold", count, 12'h000);
    repeat (3) tick();
    check("done_tc", tc, 1'b0);
    check("done_en", en_machine, 1'b1);
    check("done_hold", count, 12'h000);

    // Borrow ripples across two digits
    do_load(12'h100, 1'b0, 1'b0);
    enable = 1;
    tick();
    enable = 0;
    check("borrow_count", count, 12'h099);
    check("borrow_ssg", ssg, {7'h3F, 7'h6F, 7'h6F});

    // Up mode wrap with auto-reload
    do_load(12'h998, 1'b1, 1'b1);
    enable = 1;
    tick();
    check("up_999", count, 12'h999);
    check("up_999_tc", tc, 1'b0);
    tick();
    enable = 0;
    check("up_wrap", count, 12'h000);
    check("up_wrap_tc", tc, 1'b1);
    check("up_wrap_en", en_machine, 1'b0);
    tick();
    check("up_wrap_tc_off", tc, 1'b0);

    // Clamped load and down-mode reload
    do_load(12'h2AF, 1'b0, 1'b1);
    check("clamp_load", count, 12'h299);
    do_load(12'h000, 1'b0, 1'b1);
    load_value = 12'h020;
    enable = 1;
    tick();
    enable = 0;
    check("reload_count", count, 12'h020);
    check("reload_tc", tc, 1'b1);

    // Load wins over enable and clears the done flag
    do_load(12'h000, 1'b0, 1'b0);
    enable = 1;
    tick();
    check("pre_en_set", en_machine, 1'b1);
    do_load(12'h050, 1'b0, 1'b0);
    check("load_050", count, 12'h050);
    load = 1; enable = 1; load_value = 12'h300;
    tick();
    load = 0; enable = 0;
    check("load_prio_count", count, 12'h300);
    check("load_prio_en", en_machine, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      enable      = ($urandom_range(0, 3) != 0);
      load        = (r < 4);
      up_down     = ($urandom_range(0, 7) != 0) ? up_down : ~up_down;
      auto_reload = ($urandom_range(0, 15) != 0) ? auto_reload : ~auto_reload;
      case ($urandom_range(0, 3))
        0: load_value = 12'h000;
        1: load_value = 12'h003;
        2: load_value = 12'h996;
        default: load_value = 12'($urandom);
      endcase
      if (r == 99) begin
        reset = 0;
        #1;
        reset = 1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_ssg_counter.md
TIMER_SSG_COUNTER -- requirements
Module: timer_ssg_counter

Interface
REQ-001 Parameter DIGITS, default 3, sets the number of cascaded BCD digits (legal 1..6).
REQ-002 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port enable  input  1  count-step request, sampled each rising edge.
REQ-005 Port load  input  1  synchronous preset strobe.
REQ-006 Port up_down  input  1  direction: 1 = up, 0 = down.
REQ-007 Port auto_reload  input  1  1 = restart at terminal, 0 = stop at terminal.
REQ-008 Port load_value  input  4*DIGITS  BCD preset; digit k is bits [4k+3:4k].
REQ-009 Port count  output  4*DIGITS  registered BCD count; digit 0 is least significant.
REQ-010 Port ssg  output  7*DIGITS  seven-segment image of count; digit k is bits [7k+6:7k]; bit 0 = a ... bit 6 = g; 1 = segment lit.
REQ-011 Port tc  output  1  terminal-count pulse.
REQ-012 Port en_machine  output  1  sticky done flag for the downstream machine.

Function
REQ-013 Terminal value T: all digits 0 in down mode; all digits 9 in up mode.
REQ-014 Priority each edge: reset > load > enable step > hold.
REQ-015 load=1: count <= load_value; any digit >9 is loaded as 9; en_machine <= 0; tc <= 0.
REQ-016 Step (enable=1, load=0, en_machine=0, count != T): count +/-1 in BCD; the carry/borrow ripples across digits in the same cycle; tc <= 0.
REQ-017 Step with count == T and auto_reload=1: tc <= 1 for exactly one cycle; down mode reloads count <= load_value (clamped as REQ-015); up mode sets count <= 0.
REQ-018 Step with count == T and auto_reload=0: count holds; en_machine <= 1; tc <= 1 for one cycle.
REQ-019 While en_machine=1, enable is ignored; only load or reset clears it.
REQ-020 enable=0 and load=0: count and en_machine hold; tc <= 0.
REQ-021 ssg is a combinational decode of the count register (zero latency); digit patterns 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex, bit 6..0).
REQ-022 tc and en_machine are registered and update on the same edge as the step that caused them.
REQ-023 A change of up_down or auto_reload takes effect at the next step, with no extra cycle and no glitch on count.
REQ-024 Loaded all-zero value in down mode: the first step is a terminal step (REQ-017/018 apply).

Reset
REQ-025 reset=0 immediately forces count=0, tc=0, en_machine=0, and every ssg digit = 3F, independent of clk.
REQ-026 Reset asserted mid-count or mid-pulse aborts the operation; the first step after release counts from 0.
REQ-027 Release is synchronous-safe: no state changes on the release edge other than per REQ-014.

Structure
REQ-028 A shared package holds the BCD digit width (4), segment width (7), the 10-entry segment table, and the MAX_DIGITS limit (6).
REQ-029 One sub-module, bcd_digit, is instantiated DIGITS times; each holds one 4-bit register with load, step, up/down, carry/borrow-in, carry/borrow-out, and a terminal flag.
REQ-030 Top-level logic ANDs the per-digit terminal flags and the cascade enables, and owns tc, en_machine and the segment decode.

Verification (DIGITS=3)
REQ-031 reset low mid-count at 457 -> count=000, ssg=3F3F3F, tc=0, en_machine=0, before the next clk edge.
REQ-032 load 005, down, auto_reload=0, enable held -> 004,003,002,001,000; the next step gives tc one-cycle pulse, en_machine=1, count stays 000; further enables change nothing.
REQ-033 load 100, down, one step -> 099 (borrow across two digits in one cycle); ssg=3F6F6F.
REQ-034 up mode, auto_reload=1, count 998 -> 999, then 000 with tc pulse; en_machine stays 0.
REQ-035 load_value=0x2AF loaded -> count=299; down, auto_reload=1 at 000 with load_value 020 -> count=020, tc pulse.
REQ-036 load and enable asserted together at count 050 with load_value 300 -> count=300, no decrement, en_machine cleared.
